dmem_arbiter: RTL

Two-port arbiter that shares the single-port `data_memory` (8-bit data, 8-bit address, synchronous write, combinational read) between the CPU datapath (port 0) and the program/data loader (port 1). It sits directly in front of `data_memory` and drives its `address`, `data_in` and `write_enable` pins. It issues at most one memory access per cycle and arbitrates round-robin. A bounded lock lets a requester hold ownership for read-modify-write sequences.

---
 rtl/dmem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter with bounded lock in front of data_memory
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX);

    owner_t     owner;
    owner_t     win_owner;
    logic [3:0] lock_cnt;
    logic       prio;
    logic       lock_active;
    logic       win_sel;
    logic       win_we;
    logic       win_lock;
    logic       grant_en;

    // Lock only overrides round-robin while its budget is not yet exhausted.
    always_comb begin
        lock_active = (owner != OWN_NONE) && (lock_cnt < LOCK_LIMIT);
        win_sel     = 1'b0;
        case (req)
            2'b01:   win_sel = 1'b0;
            2'b10:   win_sel = 1'b1;
            2'b11:   win_sel = lock_active ? (owner == OWN_P1) : prio;
            default: win_sel = 1'b0;
        endcase
        win_owner = win_sel ? OWN_P1 : OWN_P0;
        win_we    = we[win_sel];
        win_lock  = lock[win_sel];
    end

    // Gating by rst_n keeps any memory write from slipping through during reset.
    assign grant_en = (|req) & rst_n;
    assign gnt      = {grant_en & win_sel, grant_en & ~win_sel};

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (grant_en) begin
            mem_addr  = win_sel ? addr1 : addr0;
            mem_wdata = win_sel ? wdata1 : wdata0;
            mem_we    = win_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            owner    <= OWN_NONE;
            lock_cnt <= 4'd0;
            rvalid   <= 2'b00;
            rdata    <= '0;
        end else begin
            rvalid <= 2'b00;
            if (grant_en) begin
                prio <= ~win_sel;
                if (!win_we) begin
                    rvalid <= gnt;
                    rdata  <= mem_rdata;
                end
                // A fresh owner, or one whose budget ran out, starts a new locked run.
                if (win_lock) begin
                    owner    <= win_owner;
                    lock_cnt <= (owner == win_owner && lock_cnt < LOCK_LIMIT) ?
                                lock_cnt + 4'd1 : 4'd1;
                end else begin
                    owner    <= OWN_NONE;
                    lock_cnt <= 4'd0;
                end
            end else begin
                owner    <= OWN_NONE;
                lock_cnt <= 4'd0;
            end
        end
    end

endmodule
